// File: rtl/hc595_rx_monitor.sv
// Receiver for the 3-wire 74HC595 display link: oversamples sclk/rclk/dio,
// rebuilds each latched frame and keeps a per-digit shadow of the display.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no bits shifted since the last latch or reset
// SHIFT | 1..FRAME_BITS bits shifted
// OVER  | more than FRAME_BITS bits shifted (595 keeps the last ones)
module hc595_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          seg_sclk,
    input  logic                          seg_rclk,
    input  logic                          seg_dio,
    output logic [FRAME_BITS-1:0]         frame_data,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic                          sel_err,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [8*NUM_DIGITS-1:0]       digit_codes
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, rclk_sync_q, dio_sync_q;
    logic                   sclk_prev_q, rclk_prev_q;
    logic                   sclk_sync, rclk_sync, dio_sync;
    logic                   sclk_rise, rclk_rise;

    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       bit_cnt;

    logic [NUM_DIGITS-1:0]  sel_n, sel_act;
    logic                   sel_blank, sel_onehot, cnt_bad;
    logic [IDX_W-1:0]       sel_idx;
    logic [7:0]             code_byte;

    // dio goes through the same depth as sclk so the sampled bit lines up
    // with the detected sclk edge; it needs no edge flop of its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            rclk_sync_q <= '0;
            dio_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            rclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], seg_sclk};
            rclk_sync_q <= {rclk_sync_q[SYNC_STAGES-2:0], seg_rclk};
            dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], seg_dio};
            sclk_prev_q <= sclk_sync;
            rclk_prev_q <= rclk_sync;
        end
    end

    assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
    assign rclk_sync = rclk_sync_q[SYNC_STAGES-1];
    assign dio_sync  = dio_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_prev_q;
    assign rclk_rise = rclk_sync & ~rclk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rclk_rise) begin
            state_d = sclk_rise ? SHIFT : IDLE;
        end else if (sclk_rise) begin
            case (state_q)
                IDLE:    state_d = SHIFT;
                SHIFT:   state_d = (bit_cnt == CNT_FULL) ? OVER : SHIFT;
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    // A coincident latch captures the pre-shift register, so the new bit
    // becomes the first bit of the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (sclk_rise) begin
                shreg <= {shreg[FRAME_BITS-2:0], dio_sync};
            end
            if (rclk_rise) begin
                bit_cnt <= sclk_rise ? CNT_W'(1) : '0;
            end else if (sclk_rise && bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_n      = shreg[NUM_DIGITS-1:0];
        sel_act    = ~sel_n;
        sel_blank  = (sel_n == '1);
        sel_onehot = (sel_act != '0) && ((sel_act & (sel_act - 1'b1)) == '0);
        code_byte  = shreg[FRAME_BITS-1 -: 8];
        cnt_bad    = (bit_cnt != CNT_FULL);
        sel_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_act[i]) begin
                sel_idx = i[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sel_err     <= 1'b0;
            digit_sel   <= '0;
            digit_codes <= '1;
        end else begin
            frame_valid <= rclk_rise;
            frame_err   <= rclk_rise & cnt_bad;
            sel_err     <= rclk_rise & ~cnt_bad & ~sel_blank & ~sel_onehot;
            if (rclk_rise) begin
                frame_data <= shreg;
                if (!cnt_bad && sel_onehot) begin
                    digit_codes[8*sel_idx +: 8] <= code_byte;
                    digit_sel                   <= sel_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx_monitor.sv
// Directed bench for hc595_rx_monitor: drives the 3-wire link slowly enough
// for the synchronizers and checks frames, errors and the digit shadow.
module tb_hc595_rx_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seg_sclk = 1'b0;
    logic        seg_rclk = 1'b0;
    logic        seg_dio = 1'b0;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic        sel_err;
    logic [2:0]  digit_sel;
    logic [63:0] digit_codes;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_codes;

    hc595_rx_monitor #(.SYNC_STAGES(2), .FRAME_BITS(16), .NUM_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .seg_sclk(seg_sclk), .seg_rclk(seg_rclk),
        .seg_dio(seg_dio), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_err(frame_err), .sel_err(sel_err), .digit_sel(digit_sel),
        .digit_codes(digit_codes)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            seg_dio = value[i];
            wait_cycles(4);
            seg_sclk = 1'b1;
            wait_cycles(4);
            seg_sclk = 1'b0;
        end
    endtask

    // Pulses rclk (optionally together with an sclk rise carrying bit b) and
    // captures the outputs in the frame_valid cycle plus frame_valid one cycle later.
    task automatic latch(input bit with_bit, input bit b, output bit got,
                         output logic [15:0] fd, output logic fe, output logic se,
                         output logic vn);
        got = 1'b0; fd = '0; fe = 1'b0; se = 1'b0; vn = 1'b0;
        if (with_bit) begin
            seg_dio = b;
            wait_cycles(4);
            seg_sclk = 1'b1;
        end
        seg_rclk = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                got = 1'b1; fd = frame_data; fe = frame_err; se = sel_err;
            end
        end
        @(negedge clk);
        vn = frame_valid;
        wait_cycles(2);
        seg_rclk = 1'b0;
        seg_sclk = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if (frame_data !== 16'h0000 || frame_valid !== 1'b0 || frame_err !== 1'b0 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b se=%b want 0000 0 0 0",
                     frame_data, frame_valid, frame_err, sel_err);
        end
        checks++;
        if (digit_codes !== 64'hFFFF_FFFF_FFFF_FFFF || digit_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_digits: got codes=%h sel=%0d want ffffffffffffffff 0", digit_codes, digit_sel);
        end
        rst = 1'b0;
        wait_cycles(4);
        exp_codes = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    task automatic test_good_frame();
        bit got; logic [15:0] fd; logic fe, se, vn;
        send_bits(32'hC0FE, 16);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        exp_codes[7:0] = 8'hC0;
        checks++;
        if (got !== 1'b1 || fd !== 16'hC0FE || fe !== 1'b0 || se !== 1'b0) begin
            errors++;
            $display("FAIL good_frame: got valid=%b data=%h fe=%b se=%b want 1 c0fe 0 0", got, fd, fe, se);
        end
        checks++;
        if (vn !== 1'b0) begin
            errors++;
            $display("FAIL good_pulse_width: frame_valid next cycle=%b want 0", vn);
        end
        checks++;
        if (digit_sel !== 3'd0 || digit_codes !== 64'hFFFF_FFFF_FFFF_FFC0) begin
            errors++;
            $display("FAIL good_digit: got sel=%0d codes=%h want 0 ffffffffffffffc0", digit_sel, digit_codes);
        end
    endtask

    task automatic test_all_digits();
        bit got; logic [15:0] fd; logic fe, se, vn;
        logic [7:0] code, sel;
        for (int k = 0; k < 8; k++) begin
            code = 8'h80 | 8'(k);
            sel = ~(8'h01 << k);
            send_bits({16'h0, code, sel}, 16);
            latch(1'b0, 1'b0, got, fd, fe, se, vn);
            checks++;
            if (got !== 1'b1 || fd !== {code, sel} || fe !== 1'b0 || se !== 1'b0 || digit_sel !== 3'(k)) begin
                errors++;
                $display("FAIL all_digits_%0d: got valid=%b data=%h fe=%b se=%b dsel=%0d want 1 %h 0 0 %0d",
                         k, got, fd, fe, se, digit_sel, {code, sel}, k);
            end
        end
        exp_codes = 64'h8786_8584_8382_8180;
        checks++;
        if (digit_codes !== 64'h8786_8584_8382_8180) begin
            errors++;
            $display("FAIL all_digits_codes: got %h want 8786858483828180", digit_codes);
        end
    endtask

    task automatic test_short_frame();
        bit got; logic [15:0] fd; logic fe, se, vn;
        send_bits(32'hABC, 12);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        checks++;
        if (got !== 1'b1 || fe !== 1'b1 || se !== 1'b0 || fd !== 16'hFABC) begin
            errors++;
            $display("FAIL short_frame: got valid=%b fe=%b se=%b data=%h want 1 1 0 fabc", got, fe, se, fd);
        end
        checks++;
        if (digit_codes !== exp_codes || digit_sel !== 3'd7) begin
            errors++;
            $display("FAIL short_no_update: got codes=%h sel=%0d want %h 7", digit_codes, digit_sel, exp_codes);
        end
        send_bits(32'h5AFE, 16);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        exp_codes[7:0] = 8'h5A;
        checks++;
        if (got !== 1'b1 || fd !== 16'h5AFE || fe !== 1'b0 || se !== 1'b0 ||
            digit_codes !== exp_codes || digit_sel !== 3'd0) begin
            errors++;
            $display("FAIL short_recover: got data=%h fe=%b se=%b codes=%h sel=%0d want 5afe 0 0 %h 0",
                     fd, fe, se, digit_codes, digit_sel, exp_codes);
        end
    endtask

    task automatic test_overflow();
        bit got; logic [15:0] fd; logic fe, se, vn;
        send_bits(32'hABCDE, 20);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        checks++;
        if (got !== 1'b1 || fd !== 16'hBCDE || fe !== 1'b1 || se !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got valid=%b data=%h fe=%b se=%b want 1 bcde 1 0", got, fd, fe, se);
        end
        checks++;
        if (digit_codes !== exp_codes) begin
            errors++;
            $display("FAIL overflow_no_update: got %h want %h", digit_codes, exp_codes);
        end
    endtask

    task automatic test_bad_select();
        bit got; logic [15:0] fd; logic fe, se, vn;
        send_bits(32'h80FC, 16);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        checks++;
        if (got !== 1'b1 || fd !== 16'h80FC || fe !== 1'b0 || se !== 1'b1) begin
            errors++;
            $display("FAIL bad_select: got valid=%b data=%h fe=%b se=%b want 1 80fc 0 1", got, fd, fe, se);
        end
        checks++;
        if (digit_codes !== exp_codes || digit_sel !== 3'd0) begin
            errors++;
            $display("FAIL bad_select_no_update: got codes=%h sel=%0d want %h 0", digit_codes, digit_sel, exp_codes);
        end
        send_bits(32'hC0FF, 16);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        checks++;
        if (got !== 1'b1 || fd !== 16'hC0FF || fe !== 1'b0 || se !== 1'b0 || digit_codes !== exp_codes) begin
            errors++;
            $display("FAIL blank_select: got data=%h fe=%b se=%b codes=%h want c0ff 0 0 %h",
                     fd, fe, se, digit_codes, exp_codes);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit got; logic [15:0] fd; logic fe, se, vn;
        bit seen_valid;
        send_bits(32'hFF, 8);
        seen_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) seen_valid = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) seen_valid = 1'b1;
        end
        exp_codes = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++;
        if (seen_valid !== 1'b0 || digit_codes !== exp_codes) begin
            errors++;
            $display("FAIL midreset_discard: valid seen=%b codes=%h want 0 %h", seen_valid, digit_codes, exp_codes);
        end
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        checks++;
        if (got !== 1'b1 || fe !== 1'b1 || se !== 1'b0 || fd !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_idle_latch: got valid=%b fe=%b se=%b data=%h want 1 1 0 0000", got, fe, se, fd);
        end
        send_bits(32'h3CF7, 16);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        exp_codes[31:24] = 8'h3C;
        checks++;
        if (got !== 1'b1 || fd !== 16'h3CF7 || fe !== 1'b0 || se !== 1'b0 ||
            digit_sel !== 3'd3 || digit_codes !== exp_codes) begin
            errors++;
            $display("FAIL midreset_clean: got data=%h fe=%b se=%b sel=%0d codes=%h want 3cf7 0 0 3 %h",
                     fd, fe, se, digit_sel, digit_codes, exp_codes);
        end
    endtask

    task automatic test_simultaneous();
        bit got; logic [15:0] fd; logic fe, se, vn;
        send_bits(32'hC1FD, 16);
        latch(1'b1, 1'b1, got, fd, fe, se, vn);
        exp_codes[15:8] = 8'hC1;
        checks++;
        if (got !== 1'b1 || fd !== 16'hC1FD || fe !== 1'b0 || se !== 1'b0 || digit_sel !== 3'd1) begin
            errors++;
            $display("FAIL simul_latch: got valid=%b data=%h fe=%b se=%b sel=%0d want 1 c1fd 0 0 1",
                     got, fd, fe, se, digit_sel);
        end
        send_bits(32'h02FB, 15);
        latch(1'b0, 1'b0, got, fd, fe, se, vn);
        exp_codes[23:16] = 8'h82;
        checks++;
        if (got !== 1'b1 || fd !== 16'h82FB || fe !== 1'b0 || se !== 1'b0 ||
            digit_sel !== 3'd2 || digit_codes !== exp_codes) begin
            errors++;
            $display("FAIL simul_next_frame: got data=%h fe=%b se=%b sel=%0d codes=%h want 82fb 0 0 2 %h",
                     fd, fe, se, digit_sel, digit_codes, exp_codes);
        end
    endtask

    initial begin
        exp_codes = 64'hFFFF_FFFF_FFFF_FFFF;
        test_reset();
        test_good_frame();
        test_all_digits();
        test_short_frame();
        test_overflow();
        test_bad_select();
        test_reset_mid_frame();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
